// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } mem_state_e;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input mem_size_e size, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  lane_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      SIZE_H:  lane_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: lane_extend = word;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input mem_size_e size, input logic [1:0] lane);
    case (size)
      SIZE_B:  lane_enable = 4'b0001 << lane;
      SIZE_H:  lane_enable = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  lane_enable = 4'b1111;
      default: lane_enable = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bus of the sized data memory.
interface data_memory_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/byte_lane_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 16
) (
  input  logic                           clk,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  input  logic                           re,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_sized.sv
// Byte/half/word load-store memory with optional zero-fill sweep after reset.
// state    | meaning
// ST_CLEAR | zeroing one word per cycle, requests blocked
// ST_IDLE  | no response pending
// ST_RESP  | response held until rsp_ready
module data_memory_sized
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 16384,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_sized_if.slave   bus,
  output logic                 busy_clear
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_e       state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rsp_write_q;
  logic             rsp_uns_q;
  mem_size_e        rsp_size_q;
  logic [1:0]       rsp_lane_q;

  mem_size_e        req_size;
  logic [1:0]       lane;
  logic             req_err;
  logic             accept;
  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  assign req_size = mem_size_e'(bus.req_size);
  assign lane     = bus.req_address[1:0];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_H:  req_err = lane[0];
      SIZE_W:  req_err = |lane;
      SIZE_X:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|bus.req_address[31:IDX_W+2]) req_err = 1'b1;
  end

  assign bus.req_ready = !reset && (state_q != ST_CLEAR) && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // The sweep owns the RAM port while clearing; requests are blocked then anyway.
  always_comb begin
    ram_we    = '0;
    ram_addr  = bus.req_address[IDX_W+1:2];
    ram_wdata = '0;
    if (state_q == ST_CLEAR) begin
      ram_we   = 4'hF;
      ram_addr = clr_idx_q;
    end else if (accept && bus.req_write && !req_err) begin
      ram_we = lane_enable(req_size, lane);
      case (req_size)
        SIZE_B:  ram_wdata = {4{bus.req_wdata[7:0]}};
        SIZE_H:  ram_wdata = {2{bus.req_wdata[15:0]}};
        default: ram_wdata = bus.req_wdata;
      endcase
    end
  end

  byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (accept),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_uns_q   <= 1'b0;
      rsp_size_q  <= SIZE_W;
      rsp_lane_q  <= '0;
    end else begin
      if (accept) begin
        rsp_err_q   <= req_err;
        rsp_write_q <= bus.req_write;
        rsp_uns_q   <= bus.req_unsigned;
        rsp_size_q  <= req_size;
        rsp_lane_q  <= lane;
      end
      case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + IDX_W'(1);
          if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (accept) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_clear    = (state_q == ST_CLEAR);
  assign bus.rsp_valid = rsp_valid_q && !reset;
  assign bus.rsp_err   = rsp_valid_q && rsp_err_q && !reset;
  assign bus.rsp_rdata = (rsp_valid_q && !reset && !rsp_write_q && !rsp_err_q)
                         ? lane_extend(ram_rdata, rsp_lane_q, rsp_size_q, rsp_uns_q) : '0;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized at DEPTH_WORDS = 16 with zero-fill enabled.
module tb_data_memory_sized;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy_clear;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [16];
  exp_t exp_q[$];
  exp_t mon_e;

  data_memory_sized_if bus();

  data_memory_sized #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy_clear (busy_clear)
  );

  always #5 clk = ~clk;

  // Independent reference model of one access.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    int idx, off;
    err = (sz == SZ_X) || (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00) || (a >= 32'd64);
    rd  = 32'h0;
    if (err) return;
    idx  = int'(a[5:2]);
    off  = int'(a[1:0]);
    word = model_mem[idx];
    if (w) begin
      case (sz)
        SZ_B:    word[off*8 +: 8]  = wd[7:0];
        SZ_H:    word[off*8 +: 16] = wd[15:0];
        default: word = wd;
      endcase
      model_mem[idx] = word;
    end else begin
      case (sz)
        SZ_B: begin
          b  = word[off*8 +: 8];
          rd = uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        SZ_H: begin
          h  = word[off*8 +: 16];
          rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: rd = word;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rsp_rdata !== mon_e.rdata || bus.rsp_err !== mon_e.err) begin
          n_bad++;
          $display("FAIL rsp addr=%h: got rdata=%h err=%b, required rdata=%h err=%b",
                   mon_e.addr, bus.rsp_rdata, bus.rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  // Presents one request, waits for acceptance, records the expected response.
  task automatic send(input logic w, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, output int waited);
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_address  = a;
    bus.req_wdata    = wd;
    #1;
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout addr=%h: req_ready=%b after %0d cycles, required 1", a, bus.req_ready, waited);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_access(w, sz, uns, a, wd, e.rdata, e.err);
    e.addr = a;
    exp_q.push_back(e);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asserts reset now and checks the outputs stay quiet for the given cycles.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL in_reset: got rsp_valid=%b req_ready=%b rsp_err=%b rsp_rdata=%h, required all 0",
                 bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata);
      end
    end
  endtask

  // Called at a negedge; releases reset and counts cycles with busy_clear high.
  task automatic release_count(output int cnt);
    reset = 1'b0;
    cnt = 0;
    while (busy_clear && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cnt, w;
    do_reset(3);
    release_count(cnt);
    n_cmp++;
    if (cnt !== 16) begin
      n_bad++;
      $display("FAIL sweep_len: got %0d cycles, required 16", cnt);
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_sweep: got %b, required 1", bus.req_ready);
    end
    send(1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, w);
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL load_latency: rsp_valid=%b one cycle after accept, required 1", bus.rsp_valid);
    end
    drain();
  endtask

  task automatic test_word_loads();
    int w;
    send(1'b1, SZ_W, 1'b0, 32'h8, 32'hDEADBEEF, w);
    send(1'b0, SZ_B, 1'b0, 32'h9, 32'h0, w);
    send(1'b0, SZ_B, 1'b1, 32'hB, 32'h0, w);
    send(1'b0, SZ_H, 1'b0, 32'hA, 32'h0, w);
    send(1'b0, SZ_H, 1'b1, 32'h8, 32'h0, w);
    send(1'b0, SZ_B, 1'b0, 32'h8, 32'h0, w);
    drain();
  endtask

  task automatic test_byte_store();
    int w;
    send(1'b1, SZ_B, 1'b0, 32'h8, 32'h00000011, w);
    send(1'b0, SZ_W, 1'b0, 32'h8, 32'h0, w);
    send(1'b1, SZ_H, 1'b0, 32'hE, 32'h12348001, w);
    send(1'b0, SZ_H, 1'b0, 32'hE, 32'h0, w);
    send(1'b0, SZ_B, 1'b1, 32'hF, 32'h0, w);
    send(1'b0, SZ_W, 1'b0, 32'hC, 32'h0, w);
    drain();
  endtask

  task automatic test_errors();
    int w;
    send(1'b1, SZ_W, 1'b0, 32'h4, 32'h01020304, w);
    send(1'b1, SZ_H, 1'b0, 32'h5, 32'h0000BEEF, w);
    send(1'b0, SZ_W, 1'b0, 32'h6, 32'h0, w);
    send(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, w);
    send(1'b1, SZ_B, 1'b0, 32'h40, 32'h000000AA, w);
    send(1'b1, SZ_X, 1'b0, 32'h0, 32'hFFFFFFFF, w);
    send(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, w);
    send(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, w);
    send(1'b0, SZ_W, 1'b0, 32'h8, 32'h0, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    exp_t held;
    bus.rsp_ready = 1'b0;
    send(1'b0, SZ_W, 1'b0, 32'h8, 32'h0, w);
    held = exp_q[0];
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = SZ_W;
    bus.req_address  = 32'h10;
    bus.req_wdata    = 32'hA5A55A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held.rdata || bus.rsp_err !== held.err || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_%0d: got valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, held.rdata, held.err);
      end
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    send(1'b1, SZ_W, 1'b0, 32'h10, 32'hA5A55A5A, w);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL b2b_store_wait: got %0d cycles, required 0", w);
    end
    send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, w);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL b2b_load_wait: got %0d cycles, required 0", w);
    end
    send(1'b1, SZ_B, 1'b0, 32'h12, 32'h0000007E, w);
    send(1'b0, SZ_B, 1'b1, 32'h12, 32'h0, w);
    send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, w);
    drain();
  endtask

  task automatic test_reset_mid();
    int w, cnt;
    send(1'b1, SZ_W, 1'b0, 32'h0, 32'h12345678, w);
    send(1'b1, SZ_W, 1'b0, 32'h3C, 32'h00000055, w);
    drain();
    bus.rsp_ready = 1'b0;
    send(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, w);
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pending_before_reset: rsp_valid=%b, required 1", bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    do_reset(2);
    release_count(cnt);
    n_cmp++;
    if (cnt !== 16) begin
      n_bad++;
      $display("FAIL sweep_after_rsp_reset: got %0d cycles, required 16", cnt);
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL dropped_rsp: rsp_valid=%b, required 0", bus.rsp_valid);
    end
    bus.rsp_ready = 1'b1;
    send(1'b1, SZ_W, 1'b0, 32'h0, 32'hCAFEF00D, w);
    send(1'b1, SZ_W, 1'b0, 32'h3C, 32'h0BADF00D, w);
    drain();
    @(posedge clk);
    #1;
    do_reset(2);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (busy_clear !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_sweep: busy_clear=%b at sweep cycle 5, required 1", busy_clear);
    end
    do_reset(2);
    release_count(cnt);
    n_cmp++;
    if (cnt !== 16) begin
      n_bad++;
      $display("FAIL sweep_restart: got %0d cycles, required 16", cnt);
    end
    send(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, w);
    send(1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, w);
    drain();
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = SZ_W;
    bus.req_unsigned = 1'b0;
    bus.req_address  = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b1;
    test_reset();
    test_word_loads();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_sized.md
DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16384, meaning the number of 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all words after reset before accepting requests.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  meaning the request is present.
REQ-006 SHALL have port req_ready  output  1  meaning the block accepts the request this cycle.
REQ-007 SHALL have port req_write  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  meaning 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port req_unsigned  input  1  meaning zero-extend (1) or sign-extend (0) sub-word loads.
REQ-010 SHALL have port req_address  input  32  meaning the byte address.
REQ-011 SHALL have port req_wdata  input  32  meaning the store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 SHALL have port rsp_valid  output  1  meaning a response is pending.
REQ-013 SHALL have port rsp_ready  input  1  meaning the consumer takes the response.
REQ-014 SHALL have port rsp_rdata  output  32  meaning load data, already extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  meaning the access was misaligned, out of range, or of illegal size.
REQ-016 SHALL have port busy_clear  output  1  meaning the zero-fill sweep is in progress.

Function
REQ-017 SHALL use a three-state FSM: CLEAR -> IDLE after the last word is zeroed; IDLE -> RESP when a request is accepted; RESP -> IDLE when rsp_ready is high and no new request is accepted; RESP -> RESP when the response is consumed and a new request is accepted in the same cycle.
REQ-018 SHALL, in CLEAR, write 0 to one word per cycle from index 0 upward, taking exactly DEPTH_WORDS cycles, with req_ready low.
REQ-019 SHALL drive req_ready = (state != CLEAR) && (!rsp_valid || rsp_ready).
REQ-020 SHALL form the word index from req_address[log2(DEPTH_WORDS)+1:2].
REQ-021 SHALL flag an error when size is half and address[0] = 1; when size is word and address[1:0] != 0; when req_size = 11; or when address >= 4*DEPTH_WORDS.
REQ-022 SHALL perform no memory write on an erroring store.
REQ-023 SHALL write bytes as follows: a byte store writes lane address[1:0] with wdata[7:0]; a half store writes lanes {address[1],0}..+1 with wdata[15:0]; a word store writes all four lanes. All other lanes SHALL be unchanged.
REQ-024 SHALL have a load latency of one cycle: rsp_valid rises on the cycle after acceptance, carrying the lane-selected data, sign- or zero-extended to 32 bits.
REQ-025 SHALL generate a response for every accepted request, including stores (rdata = 0, err as computed).
REQ-026 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
REQ-027 SHALL return the data stored by the immediately preceding accepted store to a back-to-back load to the same word.

Reset
REQ-028 SHALL, while reset is high, drive rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and req_ready = 0.
REQ-029 SHALL, after reset, enter CLEAR if CLEAR_ON_RESET = 1 (busy_clear = 1) and otherwise enter IDLE with memory contents undefined.
REQ-030 SHALL, when reset is asserted mid-sweep or mid-response, abort the sweep or response, drop any pending response, and restart the sweep at index 0.

Structure
REQ-031 SHALL take the size encodings (SIZE_B, SIZE_H, SIZE_W), the FSM state enum and the lane-extract/extend function from the shared package mem_pkg.
REQ-032 SHALL use one sub-module, byte_lane_ram, which is a DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte-write-enable and a registered read.

Verification
REQ-033 SHALL cover reset with CLEAR_ON_RESET = 1, DEPTH_WORDS = 16: busy_clear is high for 16 cycles, then req_ready = 1, and a load from 0x3C returns 0.
REQ-034 SHALL cover a store of word 0xDEADBEEF to 0x8, then lb at 0x9 -> 0xFFFFFFBE, lbu at 0xB -> 0x000000DE, lh at 0xA -> 0xFFFFDEAD.
REQ-035 SHALL cover sb 0x11 at 0x8, then lw at 0x8 -> 0xDEADBE11 (other lanes intact).
REQ-036 SHALL cover a sh to 0x5 and a lw to 0x6: both give rsp_err = 1, with memory unchanged; an address of 0x40 with depth 16 gives rsp_err = 1.
REQ-037 SHALL cover rsp_ready held low for 3 cycles: the response is stable and req_ready = 0; then on release, a back-to-back store and load to the same word complete in consecutive cycles with the correct data.
REQ-038 SHALL cover reset asserted at sweep cycle 5 and during a pending response: rsp_valid drops and the sweep restarts at 0 for the full DEPTH_WORDS cycles.
